// File: rtl/panel_pkg.sv
// rtl/panel_pkg.sv - shared row, control-bit and scan-state definitions for the front panel
package panel_pkg;

  localparam int NUM_ROWS = 3;

  localparam logic [1:0] ROW_DATA_LO = 2'd0;
  localparam logic [1:0] ROW_DATA_HI = 2'd1;
  localparam logic [1:0] ROW_CTL     = 2'd2;

  localparam int CTL_RUN          = 0;
  localparam int CTL_STOP         = 1;
  localparam int CTL_SINGLE_STEP  = 2;
  localparam int CTL_EXAMINE      = 3;
  localparam int CTL_EXAMINE_NEXT = 4;
  localparam int CTL_DEPOSIT      = 5;
  localparam int CTL_DEPOSIT_NEXT = 6;
  localparam int CTL_PANEL_RESET  = 7;

  typedef enum logic {
    SCAN_PRIME = 1'b0,
    SCAN_RUN   = 1'b1
  } scan_state_e;

  // Active-low one-hot row drive for a row index.
  function automatic logic [2:0] row_drive(input logic [1:0] row);
    return ~(3'b001 << row);
  endfunction

endpackage

// File: rtl/sw_debounce.sv
// rtl/sw_debounce.sv - one switch: disagreement counter plus stable state, advanced only on its row sample
module sw_debounce
  import panel_pkg::*;
#(
  parameter int DEBOUNCE_SCANS = 8
) (
  input  logic clk,
  input  logic resetn,
  input  logic i_en,
  input  logic i_raw,
  output logic o_stable
);

  logic [3:0] r_cnt;
  logic       r_stable;
  logic [3:0] w_cnt_inc;

  assign w_cnt_inc = r_cnt + 4'd1;
  assign o_stable  = r_stable;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cnt    <= '0;
      r_stable <= 1'b0;
    end else if (i_en) begin
      if (i_raw == r_stable) begin
        r_cnt <= '0;
      end else if (w_cnt_inc == 4'(DEBOUNCE_SCANS)) begin
        r_stable <= i_raw;
        r_cnt    <= '0;
      end else begin
        r_cnt <= w_cnt_inc;
      end
    end
  end

endmodule

// File: rtl/panel_switch_scan.sv
// rtl/panel_switch_scan.sv - front-panel switch matrix scanner: row sequencer, synchronizer, 24 debouncers, strobes
module panel_switch_scan
  import panel_pkg::*;
#(
  parameter int SCAN_DIV       = 4096,
  parameter int DEBOUNCE_SCANS = 8
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [7:0]  sw_col,
  output logic [2:0]  sw_row,
  output logic [15:0] data_sw,
  output logic [7:0]  ctl_sw,
  output logic [7:0]  cmd_pulse,
  output logic        scan_valid
);

  localparam int DW = $clog2(SCAN_DIV);

  logic [DW-1:0] r_dwell;
  logic [1:0]    r_row;
  logic [7:0]    r_sync1;
  logic [7:0]    r_sync2;
  logic [3:0]    r_scan_cnt;
  logic [7:0]    r_ctl_prev;
  scan_state_e   r_state;
  scan_state_e   w_state_next;

  logic          w_dwell_end;
  logic          w_sample;
  logic          w_scan_end;
  logic [23:0]   w_stable;

  assign w_dwell_end = (r_dwell == DW'(SCAN_DIV - 1));
  assign w_sample    = (r_dwell == DW'(SCAN_DIV - 2));
  assign w_scan_end  = w_dwell_end && (r_row == ROW_CTL);

  assign sw_row  = row_drive(r_row);
  assign data_sw = w_stable[15:0];
  assign ctl_sw  = w_stable[23:16];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_dwell    <= '0;
      r_row      <= ROW_DATA_LO;
      r_sync1    <= 8'hFF;
      r_sync2    <= 8'hFF;
      r_ctl_prev <= '0;
    end else begin
      r_dwell    <= r_dwell + 1'b1;
      r_sync1    <= sw_col;
      r_sync2    <= r_sync1;
      r_ctl_prev <= ctl_sw;
      if (w_dwell_end) begin
        r_row <= (r_row == ROW_CTL) ? ROW_DATA_LO : r_row + 2'd1;
      end
    end
  end

  // Sampling one clock before the row switch leaves the synchronizer fully flushed of the previous row.
  for (genvar r = 0; r < NUM_ROWS; r++) begin : g_row
    for (genvar c = 0; c < 8; c++) begin : g_col
      sw_debounce #(
        .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
      ) u_sw_debounce (
        .clk     (clk),
        .resetn  (resetn),
        .i_en    (w_sample && (r_row == 2'(r))),
        .i_raw   (~r_sync2[c]),
        .o_stable(w_stable[r*8+c])
      );
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state    <= SCAN_PRIME;
      r_scan_cnt <= '0;
    end else begin
      r_state <= w_state_next;
      if (r_state == SCAN_PRIME && w_scan_end) begin
        r_scan_cnt <= r_scan_cnt + 4'd1;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    cmd_pulse    = '0;
    scan_valid   = 1'b0;
    case (r_state)
      SCAN_PRIME: begin
        if (w_scan_end && (r_scan_cnt == 4'(DEBOUNCE_SCANS - 1))) begin
          w_state_next = SCAN_RUN;
        end
      end
      SCAN_RUN: begin
        scan_valid = 1'b1;
        cmd_pulse  = ctl_sw & ~r_ctl_prev;
      end
      default: w_state_next = SCAN_PRIME;
    endcase
  end

endmodule

// File: tb/tb_panel_switch_scan.sv
// tb/tb_panel_switch_scan.sv - directed bench for panel_switch_scan with SCAN_DIV=16, DEBOUNCE_SCANS=4
module tb_panel_switch_scan;

  logic        clk;
  logic        resetn;
  logic [7:0]  sw_col;
  logic [2:0]  sw_row;
  logic [15:0] data_sw;
  logic [7:0]  ctl_sw;
  logic [7:0]  cmd_pulse;
  logic        scan_valid;

  logic [7:0]  p0, p1, p2;
  int          n_cmp, n_bad;
  int          pulse_cnt, pulse_base;
  logic [7:0]  last_pulse;
  logic        seen;

  panel_switch_scan #(
    .SCAN_DIV      (16),
    .DEBOUNCE_SCANS(4)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .sw_col    (sw_col),
    .sw_row    (sw_row),
    .data_sw   (data_sw),
    .ctl_sw    (ctl_sw),
    .cmd_pulse (cmd_pulse),
    .scan_valid(scan_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Switch matrix: a closed switch pulls its column low while its row is driven.
  always_comb begin
    sw_col = 8'hFF;
    case (sw_row)
      3'b110:  sw_col = ~p0;
      3'b101:  sw_col = ~p1;
      3'b011:  sw_col = ~p2;
      default: sw_col = 8'hFF;
    endcase
  end

  always @(negedge clk) begin
    if (cmd_pulse != 8'h00) begin
      pulse_cnt  = pulse_cnt + 1;
      last_pulse = cmd_pulse;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (got !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string tag);
    seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      tick(1);
      if (scan_valid) seen = 1'b1;
    end
    check_eq(tag, {31'd0, seen}, 32'd1);
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; pulse_cnt = 0; last_pulse = 8'h00;
    p0 = 8'h00; p1 = 8'h00; p2 = 8'h00;
    resetn = 1'b0;
    tick(3);
    @(negedge clk); resetn = 1'b1;
    tick(40);

    @(negedge clk); #2 resetn = 1'b0; #1;
    check_eq("rst_row",   {29'd0, sw_row}, 32'h6);
    check_eq("rst_data",  {16'd0, data_sw}, 32'h0);
    check_eq("rst_ctl",   {24'd0, ctl_sw}, 32'h0);
    check_eq("rst_pulse", {24'd0, cmd_pulse}, 32'h0);
    check_eq("rst_valid", {31'd0, scan_valid}, 32'h0);

    @(negedge clk); resetn = 1'b1;
    tick(16);  check_eq("row1", {29'd0, sw_row}, 32'h5);
    tick(16);  check_eq("row2", {29'd0, sw_row}, 32'h3);
    tick(16);  check_eq("row0", {29'd0, sw_row}, 32'h6);
    tick(143); check_eq("valid_early", {31'd0, scan_valid}, 32'd0);
    tick(1);   check_eq("valid_rise",  {31'd0, scan_valid}, 32'd1);

    pulse_base = pulse_cnt;
    p1 = 8'h20;
    tick(174); check_eq("data_before_4th", {16'd0, data_sw}, 32'h0);
    tick(1);   check_eq("data_press",      {16'd0, data_sw}, 32'h2000);
    p1 = 8'h00;
    tick(240); check_eq("data_release", {16'd0, data_sw}, 32'h0);
    check_eq("data_no_pulse", pulse_cnt - pulse_base, 32'd0);

    for (int k = 0; k < 12; k++) begin
      p0 = (k % 4 != 3) ? 8'h08 : 8'h00;
      tick(48);
      check_eq("bounce", {16'd0, data_sw}, 32'h0);
    end
    p0 = 8'h00;

    pulse_base = pulse_cnt;
    p2 = 8'h20;
    tick(480);
    check_eq("dep_ctl",   {24'd0, ctl_sw}, 32'h20);
    check_eq("dep_count", pulse_cnt - pulse_base, 32'd1);
    check_eq("dep_value", {24'd0, last_pulse}, 32'h20);
    p2 = 8'h00;
    tick(288);
    check_eq("dep_release_ctl",   {24'd0, ctl_sw}, 32'h0);
    check_eq("dep_release_count", pulse_cnt - pulse_base, 32'd1);

    pulse_base = pulse_cnt;
    p2 = 8'h01;
    @(negedge clk); resetn = 1'b0;
    tick(5);
    @(negedge clk); resetn = 1'b1;
    wait_valid("held_valid");
    check_eq("held_ctl", {24'd0, ctl_sw}, 32'h01);
    tick(96);
    p2 = 8'h00;
    tick(288);
    check_eq("held_ctl_release", {24'd0, ctl_sw}, 32'h0);
    check_eq("held_no_pulse", pulse_cnt - pulse_base, 32'd0);

    pulse_base = pulse_cnt;
    p2 = 8'h0A;
    seen = 1'b0;
    for (int i = 0; i < 500 && !seen; i++) begin
      @(negedge clk);
      if (cmd_pulse != 8'h00) seen = 1'b1;
    end
    check_eq("simul_seen",  {31'd0, seen}, 32'd1);
    check_eq("simul_pulse", {24'd0, cmd_pulse}, 32'h0A);
    check_eq("simul_ctl",   {24'd0, ctl_sw}, 32'h0A);
    tick(10);
    check_eq("simul_count", pulse_cnt - pulse_base, 32'd1);
    p2 = 8'h00;
    tick(288);
    check_eq("simul_release", {24'd0, ctl_sw}, 32'h0);

    pulse_base = pulse_cnt;
    for (int i = 0; i < 60 && sw_row == 3'b011; i++) tick(1);
    for (int i = 0; i < 60 && sw_row != 3'b011; i++) tick(1);
    check_eq("abort_row2", {29'd0, sw_row}, 32'h3);
    p2 = 8'h02;
    tick(110);
    @(negedge clk); resetn = 1'b0; #1;
    check_eq("abort_ctl",   {24'd0, ctl_sw}, 32'h0);
    check_eq("abort_pulse", {24'd0, cmd_pulse}, 32'h0);
    tick(3);
    @(negedge clk); resetn = 1'b1;
    wait_valid("abort_valid");
    check_eq("abort_prime_ctl", {24'd0, ctl_sw}, 32'h02);
    tick(96);
    check_eq("abort_no_pulse", pulse_cnt - pulse_base, 32'd0);
    p2 = 8'h00;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
